// File: rtl/regfile_checker.sv
// regfile_checker: drives a CPU under test through a reset hold and a bounded
// run window, snoops its register-file writes into a shadow copy, then sweeps
// every captured register against a host-loaded expected-value table and
// reports each mismatch plus an overall pass/fail verdict.
module regfile_checker #(
    parameter int  XLEN       = 32,
    parameter int  NREGS      = 32,
    parameter int  RST_CYCLES = 2,
    parameter int  RUN_CYCLES = 55,
    parameter int  ERR_W      = 8,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             exp_we,
    input  logic [AW-1:0]    exp_addr,
    input  logic [XLEN-1:0]  exp_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             mm_valid,
    output logic [AW-1:0]    mm_addr,
    output logic [XLEN-1:0]  mm_exp,
    output logic [XLEN-1:0]  mm_got
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Sequencer state
    state_e           state_q;
    logic [31:0]      cnt_q;      // hold / run cycle count, or sweep index in CHECK
    logic             fin_q;      // sweep finished, verdict publishes next cycle

    // Registered outputs
    logic             cpu_rst_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic             mm_valid_q;
    logic [AW-1:0]    mm_addr_q;
    logic [XLEN-1:0]  mm_exp_q;
    logic [XLEN-1:0]  mm_got_q;

    // Storage: expected table, snooped shadow copy and its written flags
    logic [XLEN-1:0]  exp_q    [NREGS];
    logic [XLEN-1:0]  shadow_q [NREGS];
    logic [NREGS-1:0] written_q;

    // Decode
    logic             idle_like;
    logic             start_ok;
    logic             exp_addr_ok;
    logic             wb_addr_ok;
    logic [AW-1:0]    chk_idx;
    logic [XLEN-1:0]  chk_exp;
    logic [XLEN-1:0]  chk_got;
    logic             chk_written;
    logic             chk_mismatch;

    // Addresses past the last register only exist when NREGS is not a power of two.
    generate
        if (NREGS == (1 << AW)) begin : g_addr_full
            assign exp_addr_ok = 1'b1;
            assign wb_addr_ok  = 1'b1;
        end else begin : g_addr_partial
            assign exp_addr_ok = (exp_addr < AW'(NREGS));
            assign wb_addr_ok  = (wb_addr < AW'(NREGS));
        end
    endgenerate

    // Start qualification and the per-index comparison used by the sweep.
    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
        start_ok     = start && idle_like;
        chk_idx      = cnt_q[AW-1:0];
        chk_exp      = exp_q[chk_idx];
        // Register 0 is architecturally hard-wired: always written, always zero.
        chk_got      = (chk_idx == '0) ? '0 : shadow_q[chk_idx];
        chk_written  = (chk_idx == '0) || written_q[chk_idx];
        chk_mismatch = (state_q == S_CHECK) && chk_written && (chk_got != chk_exp);
    end

    // Expected-value table: host may load it only while no run is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the tables are cleared by reset because a run after reset must see all-zero expectations.
            for (int i = 0; i < NREGS; i++) begin
                exp_q[i] <= '0;
            end
        end else if (exp_we && idle_like && exp_addr_ok) begin
            exp_q[exp_addr] <= exp_data;
        end
    end

    // Shadow register file: captures CPU writes during RUN only, frozen otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= '0;
            end
            written_q <= '0;
        end else if (start_ok) begin
            // Stale shadow values are harmless once their written flags are cleared.
            written_q <= '0;
        end else if ((state_q == S_RUN) && wb_en && (wb_addr != '0) && wb_addr_ok) begin
            shadow_q[wb_addr]  <= wb_data;
            written_q[wb_addr] <= 1'b1;
        end
    end

    // Run sequencer with registered outputs: IDLE -> HOLD -> RUN -> CHECK -> DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            mm_valid_q <= 1'b0;
            mm_addr_q  <= '0;
            mm_exp_q   <= '0;
            mm_got_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            mm_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                    end else if (fin_q) begin
                        // One cycle after the last mismatch report could have appeared.
                        fin_q  <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == 32'(RST_CYCLES - 1)) begin
                        state_q   <= S_RUN;
                        cnt_q     <= '0;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_RUN: begin
                    if (halt || (cnt_q == 32'(RUN_CYCLES - 1))) begin
                        state_q   <= S_CHECK;
                        cnt_q     <= '0;
                        cpu_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (chk_mismatch) begin
                        mm_valid_q <= 1'b1;
                        mm_addr_q  <= chk_idx;
                        mm_exp_q   <= chk_exp;
                        mm_got_q   <= chk_got;
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + 1'b1;
                        end
                    end
                    if (cnt_q == 32'(NREGS - 1)) begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    cpu_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign mm_valid  = mm_valid_q;
    assign mm_addr   = mm_addr_q;
    assign mm_exp    = mm_exp_q;
    assign mm_got    = mm_got_q;

endmodule

// File: tb/tb_regfile_checker.sv
// Bench for regfile_checker: directed scenarios plus randomized runs, each run
// checked cycle by cycle against a reference model of the checker's rules.
module tb_regfile_checker;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int RST_CYCLES = 2;
    localparam int RUN_CYCLES = 55;
    localparam int ERR_W      = 2;
    localparam int AW         = 5;
    localparam int ERR_SAT    = (1 << ERR_W) - 1;
    localparam int PLAN_N     = 128;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             start    = 1'b0;
    logic             halt     = 1'b0;
    logic             exp_we   = 1'b0;
    logic [AW-1:0]    exp_addr = '0;
    logic [XLEN-1:0]  exp_data = '0;
    logic             wb_en    = 1'b0;
    logic [AW-1:0]    wb_addr  = '0;
    logic [XLEN-1:0]  wb_data  = '0;
    logic             cpu_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             mm_valid;
    logic [AW-1:0]    mm_addr;
    logic [XLEN-1:0]  mm_exp;
    logic [XLEN-1:0]  mm_got;

    regfile_checker #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .RST_CYCLES(RST_CYCLES),
        .RUN_CYCLES(RUN_CYCLES),
        .ERR_W     (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt     (halt),
        .exp_we   (exp_we),
        .exp_addr (exp_addr),
        .exp_data (exp_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .mm_valid (mm_valid),
        .mm_addr  (mm_addr),
        .mm_exp   (mm_exp),
        .mm_got   (mm_got)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: what the architectural registers should hold.
    logic [XLEN-1:0] exp_m [NREGS];
    logic [XLEN-1:0] sh_m  [NREGS];
    bit              wr_m  [NREGS];

    // Per-cycle stimulus plan, indexed by cycle number after the start edge.
    bit              p_wen   [PLAN_N];
    logic [AW-1:0]   p_waddr [PLAN_N];
    logic [XLEN-1:0] p_wdata [PLAN_N];
    bit              p_start [PLAN_N];
    bit              p_ewe   [PLAN_N];
    logic [AW-1:0]   p_eaddr [PLAN_N];
    logic [XLEN-1:0] p_edata [PLAN_N];

    int last_done_n;
    int last_mm_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            exp_m[i] = '0;
            sh_m[i]  = '0;
            wr_m[i]  = 1'b0;
        end
    endtask

    function automatic logic [XLEN-1:0] model_val(input int i);
        return (i == 0) ? '0 : sh_m[i];
    endfunction

    function automatic bit model_mismatch(input int i);
        return ((i == 0) || wr_m[i]) && (model_val(i) != exp_m[i]);
    endfunction

    task automatic clear_plan();
        for (int n = 0; n < PLAN_N; n++) begin
            p_wen[n]   = 1'b0;
            p_waddr[n] = '0;
            p_wdata[n] = '0;
            p_start[n] = 1'b0;
            p_ewe[n]   = 1'b0;
            p_eaddr[n] = '0;
            p_edata[n] = '0;
        end
    endtask

    task automatic plan_wb(input int n, input int addr, input logic [XLEN-1:0] data);
        p_wen[n]   = 1'b1;
        p_waddr[n] = AW'(addr);
        p_wdata[n] = data;
    endtask

    task automatic load_exp(input int addr, input logic [XLEN-1:0] data);
        @(negedge clk);
        exp_we   = 1'b1;
        exp_addr = AW'(addr);
        exp_data = data;
        @(negedge clk);
        exp_we   = 1'b0;
        exp_m[addr] = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rst"}, cpu_rst, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_mm_valid"}, mm_valid, 0);
        check({tag, "_mm_addr"}, mm_addr, 0);
        check({tag, "_mm_exp"}, mm_exp, 0);
        check({tag, "_mm_got"}, mm_got, 0);
    endtask

    // One test run. halt_at: RUN cycle where halt rises (-1 = never).
    // abort_n: cycle at which reset is asserted mid-run (-1 = never).
    task automatic do_run(input int halt_at, input int abort_n);
        int  run_len, n_chk0, n_done, cnt, idx;
        bit  mm_want;
        run_len     = (halt_at >= 0 && halt_at < RUN_CYCLES) ? halt_at + 1 : RUN_CYCLES;
        n_chk0      = RST_CYCLES + run_len;
        n_done      = n_chk0 + NREGS + 1;
        last_done_n = -1;
        last_mm_cnt = 0;
        for (int i = 0; i < NREGS; i++) wr_m[i] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n <= n_done + 2; n++) begin
            @(negedge clk);
            check("cpu_rst", cpu_rst, (n >= RST_CYCLES && n < n_chk0) ? 1'b0 : 1'b1);
            check("busy", busy, (n < n_chk0 + NREGS) ? 1'b1 : 1'b0);
            check("done", done, (n >= n_done) ? 1'b1 : 1'b0);
            if (n == 0) begin
                check("pass_cleared", pass, 0);
                check("err_cleared", err_count, 0);
            end
            if (done === 1'b1 && last_done_n < 0) last_done_n = n;
            mm_want = 1'b0;
            idx     = 0;
            if (n > n_chk0 && n <= n_chk0 + NREGS) begin
                idx     = n - n_chk0 - 1;
                mm_want = model_mismatch(idx);
            end
            check("mm_valid", mm_valid, mm_want);
            if (mm_valid === 1'b1) last_mm_cnt++;
            if (mm_want) begin
                check("mm_addr", mm_addr, idx);
                check("mm_exp", mm_exp, exp_m[idx]);
                check("mm_got", mm_got, model_val(idx));
            end
            if (n == abort_n) begin
                #2 rst = 1'b0;
                #1 check_reset_outputs("abort");
                start  = 1'b0;
                halt   = 1'b0;
                wb_en  = 1'b0;
                exp_we = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                model_reset();
                return;
            end
            start    = p_start[n];
            wb_en    = p_wen[n];
            wb_addr  = p_waddr[n];
            wb_data  = p_wdata[n];
            exp_we   = p_ewe[n];
            exp_addr = p_eaddr[n];
            exp_data = p_edata[n];
            if (halt_at >= 0 && n == RST_CYCLES + halt_at) halt = 1'b1;
            // Only writes landing in the run window, to a non-zero register, count.
            if (p_wen[n] && n >= RST_CYCLES && n < n_chk0 && p_waddr[n] != '0) begin
                sh_m[p_waddr[n]] = p_wdata[n];
                wr_m[p_waddr[n]] = 1'b1;
            end
        end
        start  = 1'b0;
        halt   = 1'b0;
        wb_en  = 1'b0;
        exp_we = 1'b0;
        cnt = 0;
        for (int i = 0; i < NREGS; i++) if (model_mismatch(i)) cnt++;
        check("err_count", err_count, (cnt > ERR_SAT) ? ERR_SAT : cnt);
        check("pass", pass, (cnt == 0) ? 1'b1 : 1'b0);
        check("mm_pulses", last_mm_cnt, cnt);
        check("done_latency", last_done_n, n_done);
    endtask

    task automatic rand_plan(input int run_len);
        int hi;
        clear_plan();
        hi = RST_CYCLES + run_len + NREGS;
        for (int n = 0; n <= hi + 2; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                plan_wb(n, int'($urandom_range(0, NREGS - 1)), XLEN'($urandom_range(0, 3)));
            end
        end
        // Start and table writes while busy must both be ignored.
        p_start[$urandom_range(1, hi - 1)] = 1'b1;
        begin
            int k;
            k = int'($urandom_range(0, hi - 1));
            p_ewe[k]   = 1'b1;
            p_eaddr[k] = AW'($urandom_range(0, NREGS - 1));
            p_edata[k] = XLEN'($urandom_range(4, 9));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int halt_at;
        int run_len;
        model_reset();
        clear_plan();

        // Power-on reset
        #1 rst = 1'b0;
        #10 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_cpu_rst", cpu_rst, 1);
        check("idle_done", done, 0);

        // Matching writes: clean pass
        load_exp(1, 32'h5);
        load_exp(2, 32'h7);
        clear_plan();
        plan_wb(RST_CYCLES + 3, 1, 32'h5);
        plan_wb(RST_CYCLES + 7, 2, 32'h7);
        do_run(-1, -1);

        // Single mismatch on x3
        load_exp(3, 32'h0000_000A);
        clear_plan();
        plan_wb(RST_CYCLES + 4, 3, 32'h0000_000B);
        do_run(-1, -1);
        check("x3_err", err_count, 1);

        // Unwritten x5 skipped, x0 write ignored, write during HOLD ignored
        load_exp(5, 32'hDEAD_BEEF);
        clear_plan();
        plan_wb(0, 5, 32'h1234_5678);
        plan_wb(RST_CYCLES + 1, 0, 32'hFFFF_FFFF);
        do_run(-1, -1);
        check("x5_pass", pass, 1);

        // Halt at RUN cycle 10; write in the halt cycle lands, the next one does not
        load_exp(6, 32'h11);
        clear_plan();
        plan_wb(RST_CYCLES + 10, 6, 32'h11);
        plan_wb(RST_CYCLES + 11, 6, 32'h22);
        do_run(10, -1);
        check("halt_latency", last_done_n, RST_CYCLES + 11 + NREGS + 1);

        // Five mismatches saturate a 2-bit counter
        for (int r = 7; r <= 11; r++) load_exp(r, 32'h1);
        clear_plan();
        for (int r = 7; r <= 11; r++) plan_wb(RST_CYCLES + r - 7, r, 32'h2);
        do_run(-1, -1);
        check("sat_err", err_count, 3);
        check("sat_pulses", last_mm_cnt, 5);

        // Randomized runs
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 8; k++) begin
                load_exp(int'($urandom_range(0, NREGS - 1)), XLEN'($urandom_range(0, 3)));
            end
            halt_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
            run_len = (halt_at >= 0 && halt_at < RUN_CYCLES) ? halt_at + 1 : RUN_CYCLES;
            rand_plan(run_len);
            do_run(halt_at, -1);
        end

        // Reset during CHECK discards the run
        clear_plan();
        plan_wb(RST_CYCLES + 1, 4, 32'h9);
        do_run(20, RST_CYCLES + 21 + 5);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("post_abort_done", done, 0);
            check("post_abort_busy", busy, 0);
        end

        // Clean run after reset: expected table is all zero
        clear_plan();
        plan_wb(RST_CYCLES + 2, 4, 32'h1);
        plan_wb(RST_CYCLES + 3, 9, 32'h0);
        do_run(5, -1);
        check("post_abort_err", err_count, 1);
        check("post_abort_pass", pass, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_checker.md
REGFILE_CHECKER -- requirements
Module: regfile_checker

Interface
REQ-001 Parameter XLEN, default 32, data width of register values.
REQ-002 Parameter NREGS, default 32, number of architectural registers checked; AW = $clog2(NREGS).
REQ-003 Parameter RST_CYCLES, default 2, cycles cpu_rst is held after start.
REQ-004 Parameter RUN_CYCLES, default 55, maximum cycles the CPU runs before checking.
REQ-005 Parameter ERR_W, default 8, width of the error counter.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  pulse; begins a test run from IDLE or DONE.
REQ-009 halt  in  1  level; ends RUN early (CPU end-of-program indication).
REQ-010 exp_we / exp_addr / exp_data  in  1 / AW / XLEN  expected-value table write port.
REQ-011 wb_en / wb_addr / wb_data  in  1 / AW / XLEN  snooped CPU register-file write port.
REQ-012 cpu_rst  out  1  active-high reset driven to the CPU under test.
REQ-013 busy  out  1  high in HOLD, RUN, CHECK.
REQ-014 done / pass  out  1 / 1  run complete; result valid while done=1.
REQ-015 err_count  out  ERR_W  mismatches in current run.
REQ-016 mm_valid / mm_addr / mm_exp / mm_got  out  1 / AW / XLEN / XLEN  one-cycle mismatch report.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, RUN, CHECK, DONE.
REQ-018 IDLE/DONE + start=1 -> HOLD next cycle; start SHALL clear written flags, err_count, done, pass in that same edge; start in HOLD/RUN/CHECK SHALL be ignored.
REQ-019 HOLD SHALL last exactly RST_CYCLES cycles with cpu_rst=1, then -> RUN.
REQ-020 cpu_rst SHALL be 0 only in RUN; 1 in all other states.
REQ-021 RUN SHALL last RUN_CYCLES cycles, or end the cycle after halt=1 is sampled, whichever first, then -> CHECK.
REQ-022 In RUN, wb_en=1 with wb_addr!=0 SHALL store wb_data into shadow[wb_addr] and set written[wb_addr]; writes to address 0 SHALL be ignored.
REQ-023 wb_en outside RUN SHALL be ignored (snapshot frozen during CHECK).
REQ-024 Register 0 SHALL always be treated as written with value 0.
REQ-025 exp_we SHALL write exp_table[exp_addr] only in IDLE or DONE; ignored otherwise; exp_addr >= NREGS ignored.
REQ-026 CHECK SHALL compare one index per cycle, i = 0..NREGS-1, taking exactly NREGS cycles.
REQ-027 Index with written=0 SHALL be skipped (no error, no report).
REQ-028 written=1 and shadow!=exp_table SHALL pulse mm_valid for one cycle on the following cycle with mm_addr=i, mm_exp, mm_got, and increment err_count.
REQ-029 err_count SHALL saturate at 2^ERR_W-1.
REQ-030 After index NREGS-1, -> DONE; done=1 and pass=(err_count==0) SHALL assert on the cycle after the last mm_valid opportunity, and hold until next start.
REQ-031 Total latency start->done SHALL be RST_CYCLES + run length + NREGS + 1 cycles.

Reset
REQ-032 rst=0 SHALL, asynchronously and at any state, force IDLE, cpu_rst=1, busy=0, done=0, pass=0, err_count=0, mm_valid=0, mm_addr/mm_exp/mm_got=0, clear written flags, shadow and exp_table to 0.
REQ-033 Reset mid-RUN or mid-CHECK SHALL discard the run; no done pulse follows release.

Verification
REQ-034 Load exp x1=5,x2=7; start; inject wb x1=5,x2=7 in RUN -> done=1, pass=1, err_count=0, no mm_valid.
REQ-035 Exp x3=0000000A; wb x3=0000000B -> single mm_valid with mm_addr=3, mm_exp=0000000A, mm_got=0000000B; pass=0, err_count=1.
REQ-036 Exp x5=DEADBEEF, x5 never written; wb x0=FFFFFFFF -> x5 skipped, x0 reads 0, pass=1.
REQ-037 halt=1 at RUN cycle 10 with RST_CYCLES=2, NREGS=32 -> done exactly 2+11+32+1 cycles after start; wb after halt not captured.
REQ-038 ERR_W=2, 5 mismatching registers -> err_count=3, five mm_valid pulses, pass=0.
REQ-039 rst=0 during CHECK -> all outputs at reset values immediately; start after release runs cleanly with exp_table zeroed.
